// File: rtl/tcdm_resp_pkg.sv
// tcdm_resp_pkg: shared types and helpers for the TCDM L2 responder.
//   state_e      - responder FSM states (scrub / serve)
//   resp_flags_t - per-transaction response flags carried down the latency pipe
//   word_idx()   - byte address to word index relative to a base address
package tcdm_resp_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    SERVE = 1'b1
  } state_e;

  typedef struct packed {
    logic valid;
    logic err;
    logic is_read;
  } resp_flags_t;

  // Offset arithmetic is done at 64 bits; only the low index bits are used by
  // callers, and those are identical to a subtraction at the bus width.
  function automatic logic [63:0] word_idx(input logic [63:0] add,
                                           input logic [63:0] base,
                                           input int unsigned dw);
    logic [63:0] off;
    off = add - base;
    case (dw)
      64:      return off >> 3;
      128:     return off >> 4;
      default: return off >> 2;
    endcase
  endfunction

endpackage

// File: rtl/tcdm_resp_pipe.sv
// tcdm_resp_pipe: LATENCY-deep shift register of response flags, aligning each
// accepted transaction with the SRAM read data of the same access.
//   clk_i   - clock
//   rst_i   - asynchronous active-high clear (drops all in-flight entries)
//   flags_i - flags pushed this cycle (valid=0 for idle cycles)
//   flags_o - flags of the transaction accepted LATENCY cycles ago
module tcdm_resp_pipe
  import tcdm_resp_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  resp_flags_t flags_i,
  output resp_flags_t flags_o
);

  resp_flags_t stage_q [LATENCY];
  resp_flags_t stage_d [LATENCY];

  always_comb begin
    stage_d[0] = flags_i;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign flags_o = stage_q[LATENCY-1];

endmodule

// File: rtl/tcdm_l2_responder.sv
// tcdm_l2_responder: responder end of the TCDM req/gnt/r_valid protocol for
// one L2 bank built from a single-port, fully pipelined SRAM macro.
// After reset the bank is optionally scrubbed to zero before any grant.
// Optional build macro TCDM_RESP_PERF_CNT_EN adds saturating read/write/error
// counters with a synchronous clear.
//   clk_i, rst_i          - clock, asynchronous active-high reset
//   tcdm_*_i / tcdm_*_o   - TCDM request side and response side
//   mem_*_o / mem_rdata_i - SRAM macro interface (read data MEM_LATENCY later)
//   perf_*                - performance counters (TCDM_RESP_PERF_CNT_EN only)
//   init_done_o           - high once the scrub has finished or was skipped
module tcdm_l2_responder
  import tcdm_resp_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h1C00_0000,
  parameter int unsigned           NUM_WORDS   = 8192,
  parameter int unsigned           MEM_LATENCY = 1,
  parameter int unsigned           INIT_ZERO   = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         tcdm_req_i,
  input  logic [ADDR_WIDTH-1:0]        tcdm_add_i,
  input  logic                         tcdm_wen_i,
  input  logic [DATA_WIDTH-1:0]        tcdm_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]      tcdm_be_i,
  output logic                         tcdm_gnt_o,
  output logic                         tcdm_r_valid_o,
  output logic [DATA_WIDTH-1:0]        tcdm_r_rdata_o,
  output logic                         tcdm_r_opc_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [$clog2(NUM_WORDS)-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]        mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]      mem_be_o,
  input  logic [DATA_WIDTH-1:0]        mem_rdata_i,
`ifdef TCDM_RESP_PERF_CNT_EN
  input  logic                         perf_clr_i,
  output logic [31:0]                  perf_rd_cnt_o,
  output logic [31:0]                  perf_wr_cnt_o,
  output logic [31:0]                  perf_err_cnt_o,
`endif
  output logic                         init_done_o
);

  localparam int unsigned       IDX_W      = $clog2(NUM_WORDS);
  localparam longint unsigned   BANK_BYTES = 64'(NUM_WORDS) * 64'(DATA_WIDTH / 8);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_WORDS - 1);
  localparam state_e            RST_STATE  = (INIT_ZERO != 0) ? INIT : SERVE;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      scrub_q, scrub_d;
  logic                  init_done_q, init_done_d;

  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_range;
  logic [IDX_W-1:0]      word;
  logic                  accept;
  resp_flags_t           push_flags;
  resp_flags_t           pop_flags;

  // Address decode: the subtraction wraps modulo 2^ADDR_WIDTH, so addresses
  // below the base land far above the bank and are flagged out of range.
  always_comb begin
    offset   = tcdm_add_i - BASE_ADDR;
    in_range = 64'(offset) < BANK_BYTES;
    word     = IDX_W'(word_idx(64'(tcdm_add_i), 64'(BASE_ADDR), DATA_WIDTH));
  end

  // Grant and SRAM strobes are gated by rst_i so they read 0 while reset is
  // held, even though the state register already sits in its run state.
  always_comb begin
    tcdm_gnt_o  = tcdm_req_i & (state_q == SERVE) & ~rst_i;
    accept      = tcdm_gnt_o;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = word;
    mem_wdata_o = tcdm_wdata_i;
    mem_be_o    = tcdm_be_i;
    if (state_q == INIT) begin
      mem_req_o   = ~rst_i;
      mem_we_o    = ~rst_i;
      mem_addr_o  = scrub_q;
      mem_wdata_o = '0;
      mem_be_o    = '1;
    end else if (accept && in_range) begin
      mem_req_o = 1'b1;
      mem_we_o  = ~tcdm_wen_i;
    end
  end

  always_comb begin
    state_d = state_q;
    scrub_d = scrub_q;
    if (state_q == INIT) begin
      scrub_d = scrub_q + 1'b1;
      if (scrub_q == LAST_IDX) begin
        state_d = SERVE;
      end
    end
    init_done_d = (state_d == SERVE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RST_STATE;
      scrub_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      scrub_q     <= scrub_d;
      init_done_q <= init_done_d;
    end
  end

  assign init_done_o = init_done_q;

  always_comb begin
    push_flags.valid   = accept;
    push_flags.err     = accept & ~in_range;
    push_flags.is_read = accept & tcdm_wen_i;
  end

  tcdm_resp_pipe #(
    .LATENCY (MEM_LATENCY)
  ) u_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flags_i (push_flags),
    .flags_o (pop_flags)
  );

  always_comb begin
    tcdm_r_valid_o = pop_flags.valid;
    tcdm_r_opc_o   = pop_flags.valid & pop_flags.err;
    tcdm_r_rdata_o = (pop_flags.valid && pop_flags.is_read && !pop_flags.err)
                     ? mem_rdata_i : '0;
  end

`ifdef TCDM_RESP_PERF_CNT_EN
  logic [31:0] perf_rd_q, perf_rd_d;
  logic [31:0] perf_wr_q, perf_wr_d;
  logic [31:0] perf_err_q, perf_err_d;

  always_comb begin
    perf_rd_d  = perf_rd_q;
    perf_wr_d  = perf_wr_q;
    perf_err_d = perf_err_q;
    if (perf_clr_i) begin
      perf_rd_d  = '0;
      perf_wr_d  = '0;
      perf_err_d = '0;
    end else begin
      if (accept && tcdm_wen_i && (perf_rd_q != '1)) begin
        perf_rd_d = perf_rd_q + 1'b1;
      end
      if (accept && !tcdm_wen_i && (perf_wr_q != '1)) begin
        perf_wr_d = perf_wr_q + 1'b1;
      end
      if (accept && !in_range && (perf_err_q != '1)) begin
        perf_err_d = perf_err_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_rd_q  <= '0;
      perf_wr_q  <= '0;
      perf_err_q <= '0;
    end else begin
      perf_rd_q  <= perf_rd_d;
      perf_wr_q  <= perf_wr_d;
      perf_err_q <= perf_err_d;
    end
  end

  assign perf_rd_cnt_o  = perf_rd_q;
  assign perf_wr_cnt_o  = perf_wr_q;
  assign perf_err_cnt_o = perf_err_q;
`endif

endmodule
